// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
//   state_t   : supervisor FSM states (3-bit encoding)
//   cnt_width : width of the shared phase counter, sized so it can hold the
//               longest of the reset pulse, lock timeout and stability window
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for status bits arriving from another clock domain.
// Ports:
//   clk  in        destination clock
//   rst  in        asynchronous active-high reset, clears both stages to 0
//   d    in  [W]   asynchronous input
//   q    out [W]   synchronized output, two clk edges behind d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout,
// retries a bounded number of times, requires a stable lock before releasing
// the downstream reset, and falls back to a sticky fault.
// Ports:
//   refclk        in   reference clock (only clock)
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   force_relock  in   single-cycle request to restart the whole sequence
//   pll_rst       out  reset to the PLL, active-high
//   sys_rst       out  downstream reset, active-high
//   ready         out  high only in RUN
//   fault         out  high only in FAULT
//   retry_cnt     out  lock timeouts since the last successful lock
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RST_PLL   | pll_rst held high for PLL_RST_CYCLES cycles
// WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT cycles for locked_s
// STABLE    | locked_s seen, counting LOCK_STABLE uninterrupted cycles
// RUN       | locked and stable, downstream reset released
// FAULT     | retries exhausted, held until force_relock or rst
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRY      = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_cnt
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRY);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    retry_q;
    logic [2:0]    retry_next;
    logic          locked_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

    always_comb begin
        next_state = state;
        retry_next = retry_q;
        cnt_next   = cnt;

        case (state)
            RST_PLL: begin
                if (cnt == RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins.
                if (locked_s) begin
                    next_state = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        next_state = FAULT;
                    end else begin
                        next_state = RST_PLL;
                        retry_next = retry_q + 3'd1;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                    retry_next = '0;
                end
            end
            RUN: begin
                if (!locked_s) next_state = RST_PLL;
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = RST_PLL;
            end
        endcase

        if (force_relock) begin
            next_state = RST_PLL;
            retry_next = '0;
        end

        // A relock request while already in RST_PLL restarts the pulse too.
        if (force_relock || (next_state != state)) begin
            cnt_next = '0;
        end else if (state == RST_PLL || state == WAIT_LOCK || state == STABLE) begin
            cnt_next = cnt + CW'(1);
        end
    end

    // Outputs are registered from next_state so they move with the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state   <= RST_PLL;
            cnt     <= '0;
            retry_q <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            retry_q <= retry_next;
            pll_rst <= (next_state == RST_PLL);
            sys_rst <= (next_state != RUN);
            ready   <= (next_state == RUN);
            fault   <= (next_state == FAULT);
        end
    end

    assign retry_cnt = retry_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Drives the PLL reset input and consumes the PLL `locked` output, which is the opposite end of the PLL's rst/locked interface.
- Sequences PLL reset pulses, waits for lock with a timeout, and retries a bounded number of times.
- Filters `locked` for stability, then releases the downstream system reset.
- Sits beside the PLL wrapper and runs on the 50 MHz reference clock.

Parameters:
- PLL_RST_CYCLES, 16: length of each pll_rst pulse in refclk cycles (≥2).
- LOCK_TIMEOUT, 50000: cycles to wait for lock after pll_rst drops (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive synced-locked cycles required before release.
- MAX_RETRY, 7: timeouts tolerated before fault (1..7).

Ports:
- refclk  in  1  reference clock, 50 MHz; the only clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- force_relock  in  1  synchronous single-cycle request to restart the sequence.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  downstream reset, active-high.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  3  number of lock timeouts since the last successful lock.

Behaviour:
- Reset (rst=1, asynchronous), all registered:
  - state=RST_PLL, cnt=0.
  - pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0.
  - Synchronizer flops cleared to 0.
- pll_locked passes through a 2-flop synchronizer; locked_s lags the input by 2 refclk edges. All FSM decisions use locked_s.
- One shared counter cnt, width = clog2 of max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)+1. It clears on every state change.
- FSM states and transitions:
  - RST_PLL: pll_rst=1. Go to WAIT_LOCK when cnt==PLL_RST_CYCLES-1. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
  - WAIT_LOCK: pll_rst=0.
    - If locked_s=1, go to STABLE.
    - Else if cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY go to FAULT, otherwise retry_cnt+=1 and go to RST_PLL.
    - locked_s=1 on the timeout cycle takes priority, giving STABLE.
  - STABLE: count while locked_s=1.
    - locked_s=0 gives WAIT_LOCK, with no retry increment and a fresh timeout window.
    - cnt==LOCK_STABLE-1 with locked_s=1 gives RUN.
  - RUN: ready=1, sys_rst=0. retry_cnt clears to 0 on entry. locked_s=0 gives RST_PLL, with no retry increment.
  - FAULT: pll_rst=0, sys_rst=1, fault=1. Held until force_relock or rst.
- force_relock=1 in any state gives RST_PLL with retry_cnt=0. It has priority over all other transitions.
- Output register rules:
  - pll_rst, sys_rst, ready and fault are registered from next_state. They change on the same edge as the state.
  - sys_rst = (next_state != RUN).
  - Loss of lock in RUN: sys_rst rises 3 edges after pll_locked falls (2 synchronizer + 1).
- sys_rst never deasserts without LOCK_STABLE consecutive synced-locked cycles.
- pll_rst and sys_rst are never both 0 outside RUN.
- Glitches on pll_locked shorter than one cycle may be missed. Any one-cycle drop seen in STABLE restarts stability counting.
- rst asserted mid-operation immediately returns every output to its reset value.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT), 3-bit encoding;
  - a constant function for the counter width.
- Sub-module sync_2ff: a 2-flop synchronizer with async reset to 0. It is reused for the other cross-domain status bits.

Test Plan (bench parameters PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2):
1. Release rst, PLL model asserts locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls 2+8+1 cycles after the locked rise; ready=1; retry_cnt=0.
2. locked never asserts -> 3 pll_rst pulses with retry_cnt stepping 0,1,2; the third timeout enters FAULT; fault=1, sys_rst=1, pll_rst=0, held indefinitely.
3. Locked rises, then drops for 1 cycle at stability count 5 -> returns to WAIT_LOCK with retry_cnt unchanged; release only after 8 uninterrupted cycles.
4. In RUN, deassert locked -> sys_rst=1 and ready=0 exactly 3 edges later; pll_rst pulses 4 cycles; relock recovers RUN.
5. In FAULT, pulse force_relock for 1 cycle -> next edge pll_rst=1, retry_cnt=0, fault=0; full sequence reaches RUN with the PLL model locking.
6. Assert rst asynchronously mid-STABLE and mid-RUN -> outputs reach reset values without waiting for a refclk edge; sequence restarts cleanly from RST_PLL.
